// File: rtl/rns_compare_seq_pkg.sv
// Shared types and elaboration-time helpers for the RNS comparator.
// No logic of its own; FSM encoding, result encoding and constant functions only.
package rns_compare_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Result is kept one-hot as {gt, eq, lt}
  localparam logic [2:0] CMP_NONE = 3'b000;
  localparam logic [2:0] CMP_LT   = 3'b001;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_GT   = 3'b100;

  // Brute-force modular inverse; only ever evaluated at elaboration.
  function automatic int mod_inv(input int a, input int m);
    int res;
    res = 0;
    for (int i = 1; i < m; i++) begin
      if (res == 0 && ((a * i) % m) == 1) res = i;
    end
    return res;
  endfunction

  function automatic int clog2(input int n);
    int res;
    res = 0;
    for (int v = n - 1; v > 0; v = v >> 1) res++;
    return res;
  endfunction

endpackage

// File: rtl/rns_compare_seq_mrc_step.sv
// One channel of a mixed-radix step: ((r - d) mod M) * inv mod M, combinational.
// Zero latency; no flow control of its own.
module rns_compare_seq_mrc_step #(
  parameter int W = 4,
  parameter int M = 7
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] d,
  input  logic [W-1:0] inv,
  output logic [W-1:0] r_next
);

  localparam logic [2*W-1:0] M_E = (2*W)'(M);

  logic [2*W-1:0] r_e, d_e, diff, prod;

  // The digit comes from a different modulus, so it may exceed M and is reduced first
  assign r_e    = {{W{1'b0}}, r};
  assign d_e    = {{W{1'b0}}, d} % M_E;
  assign diff   = (r_e >= d_e) ? (r_e - d_e) : (r_e + M_E - d_e);
  assign prod   = diff * {{W{1'b0}}, inv};
  assign r_next = W'(prod % M_E);

endmodule

// File: rtl/rns_compare_seq.sv
// Sequential RNS magnitude comparator via mixed-radix conversion, one digit per cycle.
// Latency N_CH cycles accept->out_valid; result held while out_ready=0, no input accepted until consumed.
// RNS_CMP_CHECK_EN adds the err port and an early exit for out-of-range residues.
module rns_compare_seq
  import rns_compare_seq_pkg::*;
#(
  parameter int                N_CH   = 3,
  parameter int                W      = 4,
  parameter logic [N_CH*W-1:0] MODULI = {4'd7, 4'd8, 4'd9}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_CH*W-1:0] x_res,
  input  logic [N_CH*W-1:0] y_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              lt,
  output logic              eq,
  output logic              gt
`ifdef RNS_CMP_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int KW = clog2(N_CH);

  state_t        state_q, state_d;
  logic [KW-1:0] k_cnt;
  logic [W-1:0]  rx      [N_CH];
  logic [W-1:0]  ry      [N_CH];
  logic [W-1:0]  rx_next [N_CH];
  logic [W-1:0]  ry_next [N_CH];
  logic [W-1:0]  dx, dy;
  logic [2:0]    cmp_q;
  logic          accept, last_step, bad_in;

  assign dx        = rx[k_cnt];
  assign dy        = ry[k_cnt];
  assign last_step = (k_cnt == KW'(N_CH - 1));
  assign accept    = in_valid & in_ready;

`ifdef RNS_CMP_CHECK_EN
  always_comb begin
    bad_in = 1'b0;
    for (int j = 0; j < N_CH; j++) begin
      if (x_res[j*W +: W] >= MODULI[j*W +: W] || y_res[j*W +: W] >= MODULI[j*W +: W])
        bad_in = 1'b1;
    end
  end
`else
  assign bad_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = bad_in ? ST_DONE : ST_CONV;
      end
      ST_CONV: if (last_step) state_d = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign {gt, eq, lt} = out_valid ? cmp_q : CMP_NONE;

  // Channel 0 never updates: its residue is already the least significant digit
  assign rx_next[0] = rx[0];
  assign ry_next[0] = ry[0];

  for (genvar j = 1; j < N_CH; j++) begin : g_ch
    localparam int MJ = int'(MODULI[j*W +: W]);
    logic [N_CH*W-1:0] inv_vec;

    for (genvar k = 0; k < N_CH; k++) begin : g_inv
      if (k < j) begin : g_lo
        assign inv_vec[k*W +: W] = W'(mod_inv(int'(MODULI[k*W +: W]) % MJ, MJ));
      end else begin : g_hi
        assign inv_vec[k*W +: W] = '0;
      end
    end

    rns_compare_seq_mrc_step #(.W(W), .M(MJ)) u_step_x (
      .r      (rx[j]),
      .d      (dx),
      .inv    (inv_vec[int'(k_cnt)*W +: W]),
      .r_next (rx_next[j])
    );

    rns_compare_seq_mrc_step #(.W(W), .M(MJ)) u_step_y (
      .r      (ry[j]),
      .d      (dy),
      .inv    (inv_vec[int'(k_cnt)*W +: W]),
      .r_next (ry_next[j])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_cnt <= '0;
      cmp_q <= CMP_NONE;
      for (int j = 0; j < N_CH; j++) begin
        rx[j] <= '0;
        ry[j] <= '0;
      end
    end else if (accept) begin
      k_cnt <= '0;
      cmp_q <= bad_in ? CMP_NONE : CMP_EQ;
      for (int j = 0; j < N_CH; j++) begin
        rx[j] <= x_res[j*W +: W];
        ry[j] <= y_res[j*W +: W];
      end
    end else if (state_q == ST_CONV) begin
      k_cnt <= k_cnt + KW'(1);
      // Later digits are more significant, so a later difference overrides
      if (dx != dy) cmp_q <= (dx > dy) ? CMP_GT : CMP_LT;
      for (int j = 0; j < N_CH; j++) begin
        if (j > int'(k_cnt)) begin
          rx[j] <= rx_next[j];
          ry[j] <= ry_next[j];
        end
      end
    end
  end

`ifdef RNS_CMP_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst)                                err_q <= 1'b0;
    else if (accept)                        err_q <= bad_in;
    else if (state_q == ST_DONE && out_ready) err_q <= 1'b0;
  end

  assign err = out_valid & err_q;
`endif

endmodule

// File: tb/tb_rns_compare_seq.sv
// Directed bench for rns_compare_seq with moduli 9/8/7 (residues packed mod7|mod8|mod9).
module tb_rns_compare_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, lt, eq, gt;
  logic [11:0] x_res, y_res;
`ifdef RNS_CMP_CHECK_EN
  logic        err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_LT   = 3'b001;
  localparam logic [2:0] F_EQ   = 3'b010;
  localparam logic [2:0] F_GT   = 3'b100;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [2:0]  exp;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  rns_compare_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_res     (x_res),
    .y_res     (y_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt)
`ifdef RNS_CMP_CHECK_EN
    ,
    .err       (err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] enc(input int v);
    return {4'(v % 7), 4'(v % 8), 4'(v % 9)};
  endfunction

  function automatic logic [2:0] model(input int a, input int b);
    if (a < b) return F_LT;
    if (a > b) return F_GT;
    return F_EQ;
  endfunction

  // Called and returns at a falling edge; lat = rising edges from accept to out_valid.
  task automatic run_cmp(input logic [11:0] x, input logic [11:0] y,
                         output logic [2:0] f, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    x_res    = x;
    y_res    = y;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    f = {gt, eq, lt};
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f;
    int         lat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x_res = '0; y_res = '0;

    vecs[0] = '{12'h321, 12'h555, F_GT};  // 10 vs 5
    vecs[1] = '{12'h638, 12'h638, F_EQ};  // 251 vs 251
    vecs[2] = '{12'h000, 12'h678, F_LT};  // 0 vs 503
    vecs[3] = '{12'h678, 12'h000, F_GT};  // 503 vs 0
    vecs[4] = '{12'h200, 12'h178, F_GT};  // 72 vs 71
    vecs[5] = '{12'h210, 12'h108, F_GT};  // 9 vs 8
    vecs[6] = '{12'h111, 12'h222, F_LT};  // 1 vs 2
    vecs[7] = '{12'h345, 12'h678, F_LT};  // 500 vs 503
    vecs[8] = '{12'h178, 12'h200, F_LT};  // 71 vs 72

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_flags", 32'({gt, eq, lt}), 32'(F_NONE));
    rst = 1'b0;
    @(negedge clk);

    // First transaction: latency and return to IDLE
    run_cmp(12'h321, 12'h555, f, lat);
    check("t1_latency", 32'(lat), 32'd3);
    check("t1_flags", 32'(f), 32'(F_GT));
    @(negedge clk);
    check("t1_in_ready_after", 32'(in_ready), 32'd1);
    check("t1_out_valid_after", 32'(out_valid), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_cmp(vecs[i].x, vecs[i].y, f, lat);
      check($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    end

    for (int i = 0; i < 504; i++) begin
      run_cmp(enc(i), enc(503 - i), f, lat);
      check($sformatf("sweep_x%0d_y%0d", i, 503 - i), 32'(f), 32'(model(i, 503 - i)));
      run_cmp(enc(i), enc(i), f, lat);
      check($sformatf("sweep_eq%0d", i), 32'(f), 32'(F_EQ));
    end

    // Backpressure with in_valid held and operands changing after accept
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x_res     = 12'h321;
    y_res     = 12'h555;
    @(posedge clk);
    @(negedge clk);
    x_res = 12'h000;
    y_res = 12'h678;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_out_valid_c%0d", c), 32'(out_valid), 32'd1);
      check($sformatf("bp_flags_c%0d", c), 32'({gt, eq, lt}), 32'(F_GT));
      check($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_flags", 32'({gt, eq, lt}), 32'(F_NONE));
    check("bp_release_in_ready", 32'(in_ready), 32'd1);

    // Reset during the second conversion cycle
    in_valid = 1'b1;
    x_res    = 12'h321;
    y_res    = 12'h555;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_conv_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_flags", 32'({gt, eq, lt}), 32'(F_NONE));
    repeat (4) @(negedge clk);
    check("mid_rst_no_result", 32'(out_valid), 32'd0);
    run_cmp(12'h321, 12'h555, f, lat);
    check("post_rst_flags", 32'(f), 32'(F_GT));
    check("post_rst_latency", 32'(lat), 32'd3);

`ifdef RNS_CMP_CHECK_EN
    @(negedge clk);
    run_cmp(12'h009, 12'h555, f, lat);
    check("err_latency", 32'(lat), 32'd0);
    check("err_flag", 32'(err), 32'd1);
    check("err_flags", 32'(f), 32'(F_NONE));
    @(negedge clk);
    check("err_cleared", 32'(err), 32'd0);
    check("err_out_valid_cleared", 32'(out_valid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
